// File: rtl/axil_slave_regfile.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers; register 0 is a read-only ID word.
// Independent write (AW/W/B) and read (AR/R) state machines with fully registered outputs.
module axil_slave_regfile #(
  parameter int          NUM_REGS = 16,
  parameter logic [31:0] ID_VALUE = 32'hA5C0_0001
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [31:0]             s_axil_awaddr,
  input  logic                    s_axil_awvalid,
  output logic                    s_axil_awready,
  input  logic [31:0]             s_axil_wdata,
  input  logic [3:0]              s_axil_wstrb,
  input  logic                    s_axil_wvalid,
  output logic                    s_axil_wready,
  output logic [1:0]              s_axil_bresp,
  output logic                    s_axil_bvalid,
  input  logic                    s_axil_bready,
  input  logic [31:0]             s_axil_araddr,
  input  logic                    s_axil_arvalid,
  output logic                    s_axil_arready,
  output logic [31:0]             s_axil_rdata,
  output logic [1:0]              s_axil_rresp,
  output logic                    s_axil_rvalid,
  input  logic                    s_axil_rready,
  output logic [32*NUM_REGS-1:0]  regs_flat
);

  localparam int IW = $clog2(NUM_REGS);

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  w_state_t    w_state_q, w_state_d;
  logic        aw_held_q, aw_held_d;
  logic        w_held_q, w_held_d;
  logic [29:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        awready_q, awready_d;
  logic        wready_q, wready_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];

  r_state_t    r_state_q, r_state_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;

  logic [IW-1:0] w_idx, ar_idx;
  logic          w_ok, ar_in_range;
  logic          unused_addr_bits;

  // Latched address holds addr[31:2]; byte offset bits never participate in decode.
  assign w_idx            = awaddr_q[IW-1:0];
  assign w_ok             = (awaddr_q[29:IW] == '0) && (w_idx != '0);
  assign ar_idx           = s_axil_araddr[IW+1:2];
  assign ar_in_range      = (s_axil_araddr[31:IW+2] == '0);
  assign unused_addr_bits = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0]};

  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;
    case (w_state_q)
      W_IDLE: begin
        if (awready_q && s_axil_awvalid) begin
          aw_held_d = 1'b1;
          awaddr_d  = s_axil_awaddr[31:2];
        end
        if (wready_q && s_axil_wvalid) begin
          w_held_d = 1'b1;
          wdata_d  = s_axil_wdata;
          wstrb_d  = s_axil_wstrb;
        end
        if (aw_held_q && w_held_q) begin
          if (w_ok) begin
            for (int b = 0; b < 4; b++) begin
              if (wstrb_q[b]) regs_d[w_idx][8*b +: 8] = wdata_q[8*b +: 8];
            end
          end
          bresp_d   = w_ok ? 2'b00 : 2'b10;
          bvalid_d  = 1'b1;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axil_bready) begin
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    regs_d[0] = ID_VALUE;
    awready_d = (w_state_d == W_IDLE) && !aw_held_d;
    wready_d  = (w_state_d == W_IDLE) && !w_held_d;
  end

  // Reads sample regs_q, so a read coinciding with a commit sees the old value.
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (arready_q && s_axil_arvalid) begin
          rdata_d   = ar_in_range ? regs_q[ar_idx] : 32'h0;
          rresp_d   = ar_in_range ? 2'b00 : 2'b10;
          rvalid_d  = 1'b1;
          r_state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (s_axil_rready) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= (k == 0) ? ID_VALUE : 32'h0;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      regs_q    <= regs_d;
    end
  end

  assign s_axil_awready = awready_q;
  assign s_axil_wready  = wready_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_arready = arready_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
    assign regs_flat[32*gi +: 32] = regs_q[gi];
  end

endmodule

// File: tb/tb_axil_slave_regfile.sv
// Randomized bench for axil_slave_regfile against an array-based register model.
module tb_axil_slave_regfile;

  localparam int          NUM_REGS = 16;
  localparam logic [31:0] ID       = 32'hA5C0_0001;

  logic        aclk = 1'b0;
  logic        areset = 1'b0;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [32*NUM_REGS-1:0] regs_flat;

  int checks = 0;
  int failures = 0;
  logic [31:0] model [NUM_REGS];

  axil_slave_regfile #(.NUM_REGS(NUM_REGS), .ID_VALUE(ID)) dut (
    .aclk(aclk), .areset(areset),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .regs_flat(regs_flat)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NUM_REGS; k++) model[k] = (k == 0) ? ID : 32'h0;
  endtask

  task automatic check_flat(input string tag);
    for (int k = 0; k < NUM_REGS; k++) check(tag, regs_flat[32*k +: 32], model[k]);
  endtask

  // lead > 0: W presented lead cycles before AW; lead < 0: AW first.
  task automatic axil_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int lead, input int bdly);
    int aw_start, w_start, c, waitc;
    bit aw_done, w_done, s_aw, s_w;
    logic [31:0] mask;
    logic [1:0] exp_resp;
    aw_start = (lead > 0) ? lead : 0;
    w_start  = (lead < 0) ? -lead : 0;
    aw_done = 0; w_done = 0; c = 0;
    while (!(aw_done && w_done) && c < 40) begin
      @(negedge aclk);
      awvalid = !aw_done && (c >= aw_start); awaddr = addr;
      wvalid  = !w_done && (c >= w_start);   wdata = data; wstrb = strb;
      s_aw = awvalid && awready;
      s_w  = wvalid && wready;
      @(posedge aclk);
      aw_done |= s_aw; w_done |= s_w; c++;
    end
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_done && w_done)) begin
      check("aw_w_accept_timeout", 32'd0, 32'd1);
      return;
    end
    check("bvalid_before_commit", bvalid, 1'b0);
    @(negedge aclk);
    check("bvalid_latency", bvalid, 1'b1);
    waitc = 0;
    while (!bvalid && waitc < 20) begin @(negedge aclk); waitc++; end
    if (!bvalid) begin
      check("bvalid_timeout", 32'd0, 32'd1);
      return;
    end
    if (addr < NUM_REGS * 4 && (addr / 4) != 0) begin
      mask = 32'h0;
      for (int b = 0; b < 4; b++) if (strb[b]) mask |= 32'hFF << (8 * b);
      model[addr / 4] = (model[addr / 4] & ~mask) | (data & mask);
      exp_resp = 2'b00;
    end else begin
      exp_resp = 2'b10;
    end
    check("bresp", bresp, exp_resp);
    check("awready_in_resp", awready, 1'b0);
    check("wready_in_resp", wready, 1'b0);
    for (int i = 0; i < bdly; i++) begin
      @(negedge aclk);
      check("bvalid_hold", bvalid, 1'b1);
      check("bresp_hold", bresp, exp_resp);
      check("awready_hold_low", awready, 1'b0);
      check("wready_hold_low", wready, 1'b0);
    end
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    check("bvalid_cleared", bvalid, 1'b0);
    check("awready_after_b", awready, 1'b1);
    check("wready_after_b", wready, 1'b1);
    check_flat("regs_flat_after_write");
    $display("WR addr=%h data=%h strb=%h lead=%0d bdly=%0d bresp=%0d", addr, data, strb, lead, bdly, bresp);
  endtask

  task automatic axil_read(input logic [31:0] addr, input int rdly);
    int c;
    logic [31:0] exp_data;
    logic [1:0] exp_resp;
    exp_data = (addr < NUM_REGS * 4) ? model[addr / 4] : 32'h0;
    exp_resp = (addr < NUM_REGS * 4) ? 2'b00 : 2'b10;
    @(negedge aclk);
    arvalid = 1'b1; araddr = addr;
    c = 0;
    while (!arready && c < 20) begin @(negedge aclk); c++; end
    if (!arready) begin
      arvalid = 1'b0;
      check("arready_timeout", 32'd0, 32'd1);
      return;
    end
    @(negedge aclk);
    arvalid = 1'b0;
    check("rvalid_latency", rvalid, 1'b1);
    check("arready_in_resp", arready, 1'b0);
    check("rdata", rdata, exp_data);
    check("rresp", rresp, exp_resp);
    for (int i = 0; i < rdly; i++) begin
      @(negedge aclk);
      check("rvalid_hold", rvalid, 1'b1);
      check("rdata_hold", rdata, exp_data);
      check("rresp_hold", rresp, exp_resp);
      check("arready_hold_low", arready, 1'b0);
    end
    rready = 1'b1;
    @(negedge aclk);
    rready = 1'b0;
    check("rvalid_cleared", rvalid, 1'b0);
    check("arready_after_r", arready, 1'b1);
    $display("RD addr=%h rdly=%0d rdata=%h rresp=%0d", addr, rdly, rdata, rresp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, awready, 1'b0);
    check({tag, "_wready"}, wready, 1'b0);
    check({tag, "_arready"}, arready, 1'b0);
    check({tag, "_bvalid"}, bvalid, 1'b0);
    check({tag, "_rvalid"}, rvalid, 1'b0);
    check({tag, "_bresp"}, bresp, 2'b00);
    check({tag, "_rresp"}, rresp, 2'b00);
    check({tag, "_rdata"}, rdata, 32'h0);
    check_flat({tag, "_regs"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old_val, addr, data;
    model_reset();
    #2 areset = 1'b1;
    #1 check_reset_outputs("por");
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    check("awready_after_rst", awready, 1'b1);
    check("wready_after_rst", wready, 1'b1);
    check("arready_after_rst", arready, 1'b1);

    axil_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0);
    axil_read(32'h04, 0);
    check("req029_reg1", regs_flat[63:32], 32'hDEADBEEF);

    axil_write(32'h08, 32'hFFFFFFFF, 4'hF, 0, 0);
    axil_write(32'h08, 32'h11223344, 4'b0101, 3, 0);
    check("req030_reg2", regs_flat[95:64], 32'hFF22FF44);

    axil_write(32'h00, 32'h12345678, 4'hF, -2, 1);
    check("req031_id", regs_flat[31:0], 32'hA5C00001);
    axil_read(32'h00, 0);

    axil_read(32'h40, 0);
    axil_write(32'h40, 32'hCAFEF00D, 4'hF, 1, 0);
    axil_write(32'h07, 32'h0BADF00D, 4'b1000, 0, 5);
    axil_read(32'h05, 5);

    for (int n = 0; n < 60; n++) begin
      addr = $urandom_range(19, 0) * 4 + $urandom_range(3, 0);
      data = $urandom;
      if ($urandom_range(1, 0) == 1)
        axil_write(addr, data, 4'($urandom_range(15, 0)), $urandom_range(6, 0) - 3, $urandom_range(3, 0));
      else
        axil_read(addr, $urandom_range(3, 0));
    end

    // Read issued on the exact edge that commits a write to the same register.
    old_val = model[3];
    data = ~old_val ^ 32'h5A5A_0000;
    @(negedge aclk);
    check("conc_awready", awready, 1'b1);
    awvalid = 1'b1; wvalid = 1'b1; awaddr = 32'h0C; wdata = data; wstrb = 4'hF;
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    arvalid = 1'b1; araddr = 32'h0C;
    @(negedge aclk);
    arvalid = 1'b0;
    model[3] = data;
    check("conc_rvalid", rvalid, 1'b1);
    check("conc_rdata_old", rdata, old_val);
    check("conc_bvalid", bvalid, 1'b1);
    check("conc_bresp", bresp, 2'b00);
    check("conc_reg3_new", regs_flat[127:96], data);
    $display("CONC addr=0c old=%h new=%h rdata=%h", old_val, data, rdata);

    // Abandon both pending responses with an asynchronous reset.
    #2 areset = 1'b1;
    model_reset();
    #1 check_reset_outputs("midrst");
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    check("awready_after_midrst", awready, 1'b1);
    check("wready_after_midrst", wready, 1'b1);
    check("arready_after_midrst", arready, 1'b1);
    for (int k = 1; k < NUM_REGS; k++) axil_read(32'(k * 4), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axil_slave_regfile.md
AXIL_SLAVE_REGFILE -- requirements
Module: axil_slave_regfile

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, number of 32-bit registers (power of 2, 2..256).
REQ-002 SHALL have parameter ID_VALUE, default 32'hA5C0_0001, constant returned by register 0.
REQ-003 SHALL have one clock, aclk, and an asynchronous, active-high reset, areset.
REQ-004 aclk  input  1  sole clock; all state updates on rising edge.
REQ-005 areset  input  1  asynchronous active-high reset.
REQ-006 s_axil_awaddr  input  32  write address; s_axil_awvalid input 1; s_axil_awready output 1.
REQ-007 s_axil_wdata  input  32; s_axil_wstrb input 4; s_axil_wvalid input 1; s_axil_wready output 1.
REQ-008 s_axil_bresp  output  2; s_axil_bvalid output 1; s_axil_bready input 1.
REQ-009 s_axil_araddr  input  32; s_axil_arvalid input 1; s_axil_arready output 1.
REQ-010 s_axil_rdata  output  32; s_axil_rresp output 2; s_axil_rvalid output 1; s_axil_rready input 1.
REQ-011 regs_flat  output  32*NUM_REGS  current register contents, reg k at bits [32k+31:32k]; slice 0 = ID_VALUE.

Function
REQ-012 Decode: word index = addr[log2(NUM_REGS)+1:2]; address valid only if addr < NUM_REGS*4; addr[1:0] ignored.
REQ-013 Register 0 SHALL be read-only, always ID_VALUE; registers 1..NUM_REGS-1 read/write.
REQ-014 Write FSM states: W_IDLE (collect AW/W), W_RESP (bvalid high).
REQ-015 awready SHALL be high in W_IDLE while no address is latched; wready high in W_IDLE while no data is latched; AW and W accepted independently, in either order or the same cycle.
REQ-016 Cycle after both AW and W are held: commit write, set bvalid, go to W_RESP; with AW and W handshaking in the same cycle, bvalid rises exactly 1 cycle later.
REQ-017 Commit: for each byte i with wstrb[i]=1, reg[idx][8i+7:8i] <= wdata[8i+7:8i]; strobe-0 bytes unchanged.
REQ-018 bresp SHALL be 2'b00 (OKAY) for in-range index 1..NUM_REGS-1; 2'b10 (SLVERR) for out-of-range address or index 0, with no register change.
REQ-019 bvalid and bresp SHALL hold stable until bready=1; on handshake clear latches, return to W_IDLE; awready/wready low throughout W_RESP.
REQ-020 Read FSM states: R_IDLE (arready=1), R_RESP (rvalid=1, arready=0).
REQ-021 On AR handshake, rdata/rresp SHALL be registered and rvalid asserted the next cycle (latency 1).
REQ-022 Out-of-range read: rdata=32'h0, rresp=2'b10; in-range read (incl. index 0): rresp=2'b00.
REQ-023 rvalid, rdata, rresp SHALL hold stable until rready=1; on handshake return to R_IDLE; arready rises the following cycle.
REQ-024 Read and write channels SHALL operate concurrently; a read sampled in the same cycle as a write commit to the same register returns the pre-write value.
REQ-025 Valid-before-ready and ready-independent-of-valid SHALL be honoured; no output combinationally depends on any input.

Reset
REQ-026 On areset=1, immediately: awready=wready=arready=0, bvalid=rvalid=0, bresp=rresp=2'b00, rdata=0, regs 1..NUM_REGS-1 = 0, latches cleared, FSMs in W_IDLE/R_IDLE.
REQ-027 First cycle after areset deasserts: awready=wready=arready=1.
REQ-028 Reset mid-transaction SHALL abandon it: pending bvalid/rvalid drop; partially applied writes impossible (commit is single-cycle).

Verification
REQ-029 AW+W same cycle, addr 0x04, data 0xDEADBEEF, strb 4'hF -> bvalid 1 cycle later, bresp 00; read 0x04 -> rdata 0xDEADBEEF, rresp 00.
REQ-030 W 3 cycles before AW, addr 0x08, data 0x11223344, strb 4'b0101 over 0xFFFFFFFF -> reg2 = 0xFF22FF44, bresp 00.
REQ-031 Write 0x0 data 0x12345678 -> bresp 10, regs_flat[31:0] stays 0xA5C00001; read 0x0 -> 0xA5C00001, rresp 00.
REQ-032 Read 0x40 (NUM_REGS=16) -> rdata 0, rresp 10; write 0x40 -> bresp 10, no register change.
REQ-033 bready/rready held low 5 cycles -> bvalid/rvalid and data stable, awready/wready/arready low; release -> accept new request next cycle.
REQ-034 areset asserted while bvalid=1 and rvalid=1 -> all outputs at reset values same cycle; regs 1..15 read back 0 after release.
